// File: rtl/seqdiv_if.sv
// Bundles the request/result handshake and the external ALU operand bus of the sequential divider.
// The divider sits on the slave side; the requester that also owns the ALU sits on the master side.
interface seqdiv_if;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        divbyzero;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_cout;

    modport slave (
        input  start, dividend, divisor, alu_result, alu_cout,
        output busy, done, quotient, remainder, divbyzero, alu_a, alu_b, alu_op
    );

    modport master (
        output start, dividend, divisor, alu_result, alu_cout,
        input  busy, done, quotient, remainder, divbyzero, alu_a, alu_b, alu_op
    );
endinterface

// File: rtl/seqdiv.sv
// Restoring 32-bit unsigned divider, one quotient bit per cycle; every trial subtraction
// is delegated to an external ALU through the alu_a/alu_b/alu_op bus.
module seqdiv #(
    parameter int N_STEPS = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    seqdiv_if.slave  dif
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [4:0] LAST_STEP = 5'(N_STEPS - 1);
    localparam logic [2:0] OP_SUB    = 3'b110;

    state_t      state_q;
    logic [31:0] q_q, r_q, d_q;
    logic [4:0]  cnt_q;
    logic [31:0] quotient_q, remainder_q;
    logic        busy_q, done_q, divbyzero_q;

    logic [31:0] shift_d, q_d, r_d;
    logic        take_d;

    // A set shifted-out bit means the 33-bit partial remainder already exceeds D, so the
    // wrapped 32-bit ALU difference is the correct new remainder.
    always_comb begin
        shift_d = {r_q[30:0], q_q[31]};
        take_d  = r_q[31] | dif.alu_cout;
        q_d     = {q_q[30:0], take_d};
        r_d     = take_d ? dif.alu_result : shift_d;
    end

    assign dif.alu_op    = OP_SUB;
    assign dif.alu_a     = (state_q == RUN) ? shift_d : 32'd0;
    assign dif.alu_b     = (state_q == RUN) ? d_q : 32'd0;
    assign dif.busy      = busy_q;
    assign dif.done      = done_q;
    assign dif.quotient  = quotient_q;
    assign dif.remainder = remainder_q;
    assign dif.divbyzero = divbyzero_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            q_q         <= '0;
            r_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            divbyzero_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (dif.start) begin
                        if (dif.divisor != 32'd0) begin
                            q_q     <= dif.dividend;
                            r_q     <= '0;
                            d_q     <= dif.divisor;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end else begin
                            quotient_q  <= '1;
                            remainder_q <= dif.dividend;
                            divbyzero_q <= 1'b1;
                            done_q      <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                RUN: begin
                    q_q   <= q_d;
                    r_q   <= r_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == LAST_STEP) begin
                        quotient_q  <= q_d;
                        remainder_q <= r_d;
                        divbyzero_q <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seqdiv.sv
// Randomised self-checking bench for seqdiv: the bench plays the external ALU and compares
// every result against plain integer division.
module tb_seqdiv;
    logic clk;
    logic rst_n;
    int   checkCount;
    int   errorCount;

    seqdiv_if dif ();

    seqdiv #(.N_STEPS(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dif   (dif)
    );

    // External ALU: subtract with unsigned no-borrow flag; any other opcode adds instead.
    assign dif.alu_result = (dif.alu_op == 3'b110) ? dif.alu_a - dif.alu_b : dif.alu_a + dif.alu_b;
    assign dif.alu_cout   = (dif.alu_op == 3'b110) ? (dif.alu_a >= dif.alu_b) : 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Runs one division; glitchAt>0 pulses start with fresh operands during that RUN cycle.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input int glitchAt);
        logic [31:0] expQ, expR;
        int          cycles;
        logic        sawBusy, aluOk;
        expQ = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
        expR = (b == 32'd0) ? a : a % b;
        @(negedge clk);
        dif.start = 1'b1; dif.dividend = a; dif.divisor = b;
        @(negedge clk);
        dif.start = 1'b0; dif.dividend = $urandom; dif.divisor = $urandom;
        cycles = 1; sawBusy = 1'b0; aluOk = 1'b1;
        while (!dif.done && cycles < 40) begin
            if (dif.busy) begin
                sawBusy = 1'b1;
                if (dif.alu_op !== 3'b110 || dif.alu_b !== b) aluOk = 1'b0;
            end
            @(negedge clk);
            cycles++;
            dif.start = (cycles == glitchAt);
            if (cycles == glitchAt) begin
                dif.dividend = $urandom;
                dif.divisor  = $urandom_range(1, 50);
            end
        end
        dif.start = 1'b0;
        checkOutput("latency",   32'(cycles), (b == 32'd0) ? 32'd1 : 32'd33);
        checkOutput("quotient",  dif.quotient, expQ);
        checkOutput("remainder", dif.remainder, expR);
        checkOutput("divbyzero", {31'd0, dif.divbyzero}, {31'd0, b == 32'd0});
        checkOutput("busySeen",  {31'd0, sawBusy}, {31'd0, b != 32'd0});
        checkOutput("aluBusRun", {31'd0, aluOk}, 32'd1);
        checkOutput("aluAIdle",  dif.alu_a, 32'd0);
        checkOutput("aluBIdle",  dif.alu_b, 32'd0);
    endtask

    initial begin
        logic        quiet;
        logic [31:0] ra, rb;
        checkCount = 0;
        errorCount = 0;
        rst_n = 1'b0;
        dif.start = 1'b0; dif.dividend = '0; dif.divisor = '0;

        #3;
        checkOutput("rstBusy",      {31'd0, dif.busy}, 32'd0);
        checkOutput("rstDone",      {31'd0, dif.done}, 32'd0);
        checkOutput("rstQuotient",  dif.quotient, 32'd0);
        checkOutput("rstRemainder", dif.remainder, 32'd0);
        checkOutput("rstDivByZero", {31'd0, dif.divbyzero}, 32'd0);
        checkOutput("aluOp",        {29'd0, dif.alu_op}, 32'd6);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed vectors");
        applyStimulus(32'd100, 32'd7, -1);
        applyStimulus(32'hFFFF_FFFF, 32'd1, -1);
        applyStimulus(32'hFFFF_FFFF, 32'h8000_0001, -1);
        applyStimulus(32'h1234, 32'd0, -1);

        // Start during RUN must be ignored; the following start lands in the IDLE cycle after done.
        $display("[TB] ignored start and back-to-back");
        applyStimulus(32'd500, 32'd9, 5);
        applyStimulus(32'd77777, 32'd123, -1);

        repeat (3) @(negedge clk);
        checkOutput("holdQuotient",  dif.quotient, 32'd632);
        checkOutput("holdRemainder", dif.remainder, 32'd41);
        checkOutput("holdDone",      {31'd0, dif.done}, 32'd0);

        $display("[TB] reset mid-run");
        @(negedge clk);
        dif.start = 1'b1; dif.dividend = 32'd12345; dif.divisor = 32'd67;
        @(negedge clk);
        dif.start = 1'b0;
        repeat (9) @(negedge clk);
        checkOutput("busyBeforeAbort", {31'd0, dif.busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abortBusy",      {31'd0, dif.busy}, 32'd0);
        checkOutput("abortDone",      {31'd0, dif.done}, 32'd0);
        checkOutput("abortQuotient",  dif.quotient, 32'd0);
        checkOutput("abortRemainder", dif.remainder, 32'd0);
        checkOutput("abortDivByZero", {31'd0, dif.divbyzero}, 32'd0);
        checkOutput("abortAluA",      dif.alu_a, 32'd0);
        checkOutput("abortAluB",      dif.alu_b, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (dif.done || dif.busy) quiet = 1'b0;
        end
        checkOutput("quietAfterAbort", {31'd0, quiet}, 32'd1);
        applyStimulus(32'd10, 32'd3, -1);

        $display("[TB] random vectors");
        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 255);
                2:       rb = $urandom | 32'h8000_0000;
                default: rb = $urandom;
            endcase
            applyStimulus(ra, rb, -1);
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end
endmodule
